// File: rtl/mips_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    RESP  = 2'd3
  } arbState_e;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  // Bits needed to count from 0 up to and including limit.
  function automatic int counterWidth(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating count of data grants taken while a fetch was waiting.
module starve_counter
  import mips_mem_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_atLimit
);

  localparam int W = counterWidth(LIMIT);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] r_count;

  // Clear wins over increment so a fetch grant always restarts the window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT_V)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_atLimit = (r_count == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single handshaked memory port,
// data-first with a starvation cap for pending fetches.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [31:0]       IRData,
  output logic              IReady,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [31:0]       DWData,
  input  logic [3:0]        DMask,
  output logic [31:0]       DRData,
  output logic              DReady,
  output logic              MemValid,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic [3:0]        MemMask,
  input  logic [31:0]       MemRData,
  input  logic              MemAck
);

  arbState_e r_state;
  arbState_e w_nextState;
  logic      w_grantI;
  logic      w_grantD;
  logic      w_done;
  logic      w_atLimit;

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_grantD & IReq),
    .i_clr    (w_grantI),
    .o_atLimit(w_atLimit)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Acks outside a grant state fall through untouched and are ignored.
  always_comb begin
    w_nextState = r_state;
    w_grantI    = 1'b0;
    w_grantD    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (DReq && (!w_atLimit || !IReq)) begin
          w_nextState = GNT_D;
          w_grantD    = 1'b1;
        end else if (IReq) begin
          w_nextState = GNT_I;
          w_grantI    = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (MemAck) begin
          w_nextState = RESP;
          w_done      = 1'b1;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      MemValid <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      MemMask  <= '0;
      IReady   <= 1'b0;
      DReady   <= 1'b0;
      IRData   <= '0;
      DRData   <= '0;
    end else begin
      IReady <= 1'b0;
      DReady <= 1'b0;
      if (w_grantD) begin
        MemValid <= 1'b1;
        MemWe    <= DWe;
        MemAddr  <= DAddr;
        MemWData <= DWData;
        MemMask  <= DMask;
      end else if (w_grantI) begin
        MemValid <= 1'b1;
        MemWe    <= 1'b0;
        MemAddr  <= IAddr;
        MemWData <= '0;
        MemMask  <= '0;
      end
      if (w_done) begin
        MemValid <= 1'b0;
        if (r_state == GNT_I) begin
          IRData <= MemRData;
          IReady <= 1'b1;
        end else begin
          DRData <= MemRData;
          DReady <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks for mem_arbiter: a per-cycle vector table followed by
// hand-written arbitration and starvation sequences.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              reset;
  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic [31:0]       IRData;
  logic              IReady;
  logic              DReq;
  logic              DWe;
  logic [ADDR_W-1:0] DAddr;
  logic [31:0]       DWData;
  logic [3:0]        DMask;
  logic [31:0]       DRData;
  logic              DReady;
  logic              MemValid;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWData;
  logic [3:0]        MemMask;
  logic [31:0]       MemRData;
  logic              MemAck;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [31:0] rst, iReq, iAddr, dReq, dWe, dAddr, dWData, dMask, memAck, memRData;
    logic [31:0] eValid, eWe, eAddr, eWData, eMask, eIReady, eIRData, eDReady, eDRData;
  } vec_t;

  localparam int NUM_VECS = 19;
  vec_t vecs [NUM_VECS];

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .IReq    (IReq),
    .IAddr   (IAddr),
    .IRData  (IRData),
    .IReady  (IReady),
    .DReq    (DReq),
    .DWe     (DWe),
    .DAddr   (DAddr),
    .DWData  (DWData),
    .DMask   (DMask),
    .DRData  (DRData),
    .DReady  (DReady),
    .MemValid(MemValid),
    .MemWe   (MemWe),
    .MemAddr (MemAddr),
    .MemWData(MemWData),
    .MemMask (MemMask),
    .MemRData(MemRData),
    .MemAck  (MemAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset    = v.rst[0];
    IReq     = v.iReq[0];
    IAddr    = v.iAddr[ADDR_W-1:0];
    DReq     = v.dReq[0];
    DWe      = v.dWe[0];
    DAddr    = v.dAddr[ADDR_W-1:0];
    DWData   = v.dWData;
    DMask    = v.dMask[3:0];
    MemAck   = v.memAck[0];
    MemRData = v.memRData;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, ".MemValid"}, 32'(MemValid), v.eValid);
    checkVal({tag, ".MemWe"},    32'(MemWe),    v.eWe);
    checkVal({tag, ".MemAddr"},  32'(MemAddr),  v.eAddr);
    checkVal({tag, ".MemWData"}, MemWData,      v.eWData);
    checkVal({tag, ".MemMask"},  32'(MemMask),  v.eMask);
    checkVal({tag, ".IReady"},   32'(IReady),   v.eIReady);
    checkVal({tag, ".IRData"},   IRData,        v.eIRData);
    checkVal({tag, ".DReady"},   32'(DReady),   v.eDReady);
    checkVal({tag, ".DRData"},   DRData,        v.eDRData);
  endtask

  task automatic fillVectors();
    //         rst iReq iAddr  dReq dWe dAddr    dWData         dMask ack rdata            valid we addr     wdata          mask iRdy iRData         dRdy dRData
    vecs[0]  = '{0, 0, 0,      0, 0, 0,       0,             0, 0, 0,             0, 0, 0,       0,             0, 0, 0,             0, 0};
    vecs[1]  = '{0, 0, 0,      0, 0, 0,       0,             0, 0, 0,             0, 0, 0,       0,             0, 0, 0,             0, 0};
    vecs[2]  = '{1, 0, 0,      0, 0, 0,       0,             0, 1, 'h12345678,    0, 0, 0,       0,             0, 0, 0,             0, 0};
    vecs[3]  = '{1, 1, 'h100,  0, 0, 0,       0,             0, 0, 0,             1, 0, 'h100,   0,             0, 0, 0,             0, 0};
    vecs[4]  = '{1, 1, 'h100,  0, 0, 0,       0,             0, 0, 0,             1, 0, 'h100,   0,             0, 0, 0,             0, 0};
    vecs[5]  = '{1, 1, 'h100,  0, 0, 0,       0,             0, 1, 'h8C010004,    0, 0, 'h100,   0,             0, 1, 'h8C010004,    0, 0};
    vecs[6]  = '{1, 1, 'h100,  0, 0, 0,       0,             0, 1, 'hFFFFFFFF,    0, 0, 'h100,   0,             0, 0, 'h8C010004,    0, 0};
    vecs[7]  = '{1, 0, 0,      0, 0, 0,       0,             0, 0, 0,             0, 0, 'h100,   0,             0, 0, 'h8C010004,    0, 0};
    vecs[8]  = '{1, 0, 0,      1, 1, 'h2000,  'hDEADBEEF,    3, 0, 0,             1, 1, 'h2000,  'hDEADBEEF,    3, 0, 'h8C010004,    0, 0};
    vecs[9]  = '{1, 0, 0,      1, 1, 'h2000,  'hDEADBEEF,    3, 0, 0,             1, 1, 'h2000,  'hDEADBEEF,    3, 0, 'h8C010004,    0, 0};
    vecs[10] = '{1, 0, 0,      1, 1, 'h2000,  'hDEADBEEF,    3, 0, 0,             1, 1, 'h2000,  'hDEADBEEF,    3, 0, 'h8C010004,    0, 0};
    vecs[11] = '{1, 0, 0,      1, 1, 'h2000,  'hDEADBEEF,    3, 0, 0,             1, 1, 'h2000,  'hDEADBEEF,    3, 0, 'h8C010004,    0, 0};
    vecs[12] = '{1, 0, 0,      1, 1, 'h2000,  'hDEADBEEF,    3, 1, 'h0BADF00D,    0, 1, 'h2000,  'hDEADBEEF,    3, 0, 'h8C010004,    1, 'h0BADF00D};
    vecs[13] = '{1, 0, 0,      1, 1, 'h2000,  'hDEADBEEF,    3, 0, 0,             0, 1, 'h2000,  'hDEADBEEF,    3, 0, 'h8C010004,    0, 'h0BADF00D};
    vecs[14] = '{1, 0, 0,      0, 0, 0,       0,             0, 0, 0,             0, 1, 'h2000,  'hDEADBEEF,    3, 0, 'h8C010004,    0, 'h0BADF00D};
    vecs[15] = '{1, 0, 0,      1, 0, 'h3000,  0,             0, 0, 0,             1, 0, 'h3000,  0,             0, 0, 'h8C010004,    0, 'h0BADF00D};
    vecs[16] = '{0, 0, 0,      1, 0, 'h3000,  0,             0, 0, 0,             0, 0, 0,       0,             0, 0, 0,             0, 0};
    vecs[17] = '{1, 0, 0,      0, 0, 0,       0,             0, 1, 'hCAFEF00D,    0, 0, 0,       0,             0, 0, 0,             0, 0};
    vecs[18] = '{1, 0, 0,      0, 0, 0,       0,             0, 0, 0,             0, 0, 0,       0,             0, 0, 0,             0, 0};
  endtask

  // One full transaction from IDLE: grant, ack, then back to IDLE.
  task automatic runTransaction(input string tag, input bit expectData,
                                input logic [31:0] expAddr, input logic [31:0] rdata);
    MemAck = 1'b0;
    step();
    checkVal({tag, ".grantValid"}, 32'(MemValid), 32'd1);
    checkVal({tag, ".grantAddr"},  32'(MemAddr),  expAddr);
    checkVal({tag, ".grantWe"},    32'(MemWe),    32'd0);
    MemAck   = 1'b1;
    MemRData = rdata;
    step();
    MemAck = 1'b0;
    checkVal({tag, ".DReady"}, 32'(DReady), expectData ? 32'd1 : 32'd0);
    checkVal({tag, ".IReady"}, 32'(IReady), expectData ? 32'd0 : 32'd1);
    checkVal({tag, ".rdata"},  expectData ? DRData : IRData, rdata);
    step();
    checkVal({tag, ".idleValid"}, 32'(MemValid), 32'd0);
    checkVal({tag, ".idleReady"}, 32'(IReady | DReady), 32'd0);
  endtask

  initial begin
    reset = 1'b0; IReq = 1'b0; IAddr = '0; DReq = 1'b0; DWe = 1'b0;
    DAddr = '0; DWData = '0; DMask = '0; MemAck = 1'b0; MemRData = '0;
    fillVectors();

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Simultaneous requests with an empty starve count: data first, then fetch.
    IReq = 1'b1; IAddr = 32'h400;
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h500; DWData = '0; DMask = '0;
    MemAck = 1'b0;
    step();
    checkVal("simul.firstAddr", 32'(MemAddr), 32'h500);
    MemAck = 1'b1; MemRData = 32'h11111111;
    step();
    checkVal("simul.DReady", 32'(DReady), 32'd1);
    checkVal("simul.IReady", 32'(IReady), 32'd0);
    MemAck = 1'b0; DReq = 1'b0;
    step();
    checkVal("simul.respNoGrant", 32'(MemValid), 32'd0);
    step();
    checkVal("simul.fetchValid", 32'(MemValid), 32'd1);
    checkVal("simul.fetchAddr",  32'(MemAddr),  32'h400);
    MemAck = 1'b1; MemRData = 32'h22222222;
    step();
    checkVal("simul.fetchReady", 32'(IReady), 32'd1);
    checkVal("simul.fetchData",  IRData, 32'h22222222);
    MemAck = 1'b0; IReq = 1'b0;
    step();

    // Back-to-back data with a fetch pending: four data grants, one fetch, data again.
    IReq = 1'b1; IAddr = 32'h700;
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h600;
    for (int k = 0; k < 7; k++) begin
      automatic bit isData = (k != 4);
      runTransaction($sformatf("starve%0d", k), isData,
                     isData ? 32'h600 : 32'h700, 32'hA0000000 + 32'(k));
    end
    IReq = 1'b0; DReq = 1'b0;
    step();
    checkVal("final.idle", 32'(MemValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
